// File: rtl/arch_defs_pkg.sv
// Shared control-path definitions for the SAP-2 CPU: fetch sequencer states
// and the architectural instruction-length limit.
package arch_defs_pkg;

    localparam int MAX_INSTR_BYTES = 3;

    typedef enum logic [2:0] {
        BOOT,
        INIT_SP,
        LATCH_ADDRESS,
        READ_BYTE,
        LATCH_BYTE,
        CHK_MORE_BYTES,
        EXECUTE,
        HALTED
    } fetch_state_t;

    function automatic logic is_fetch_state(input fetch_state_t s);
        return (s == LATCH_ADDRESS) || (s == READ_BYTE) ||
               (s == LATCH_BYTE)    || (s == CHK_MORE_BYTES);
    endfunction

endpackage

// File: rtl/operand_shift_reg.sv
// Operand byte lanes for the fetch sequencer. Lane k-1 is written when the
// write index equals k (byte 0 is the opcode and lives elsewhere).
module operand_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_LANES  = 2,
    parameter int IDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr_i,
    input  logic                            wr_en_i,
    input  logic [IDX_W-1:0]                wr_idx_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lanes_o
);

    logic [NUM_LANES*DATA_WIDTH-1:0] lanes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
        end else if (clr_i) begin
            lanes_q <= '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (wr_idx_i == IDX_W'(k + 1)) begin
                    lanes_q[k*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i;
                end
            end
        end
    end

    assign lanes_o = lanes_q;

endmodule

// File: rtl/multi_byte_fetch_fsm.sv
// Variable-length instruction fetch sequencer: reads opcode plus operand bytes
// through the MAR, then hands off to the execute microsequencer.
module multi_byte_fetch_fsm
    import arch_defs_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    MAX_BYTES    = MAX_INSTR_BYTES,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(16'hF000),
    parameter int                    LEN_W        = $clog2(MAX_BYTES + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [LEN_W-1:0]                  instr_len,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_ready,
    input  logic                              exec_done,
    input  logic                              pc_load,
    input  logic [ADDR_WIDTH-1:0]             pc_load_value,
    input  logic                              halt_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_read,
    output logic [ADDR_WIDTH-1:0]             pc,
    output logic [DATA_WIDTH-1:0]             opcode,
    output logic [(MAX_BYTES-1)*DATA_WIDTH-1:0] operands,
    output logic                              init_sp,
    output logic                              exec_start,
    output logic                              fetch_busy,
    output logic                              halted,
    output logic                              len_error
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    fetch_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [LEN_W-1:0]        byte_idx_q, byte_idx_d;
    logic                    halted_q, halted_d;
    logic                    len_error_q, len_error_d;
    logic                    fetch_busy_q;
    logic                    op_clr, op_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= '0;
            mem_addr_q   <= '0;
            opcode_q     <= '0;
            byte_idx_q   <= '0;
            halted_q     <= 1'b0;
            len_error_q  <= 1'b0;
            fetch_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            opcode_q     <= opcode_d;
            byte_idx_q   <= byte_idx_d;
            halted_q     <= halted_d;
            len_error_q  <= len_error_d;
            fetch_busy_q <= is_fetch_state(state_d);
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        opcode_d    = opcode_q;
        byte_idx_d  = byte_idx_q;
        halted_d    = halted_q;
        len_error_d = len_error_q;
        op_clr      = 1'b0;
        op_wr       = 1'b0;
        mem_read    = 1'b0;
        init_sp     = 1'b0;
        exec_start  = 1'b0;

        case (state_q)
            BOOT: begin
                pc_d    = RESET_VECTOR;
                state_d = INIT_SP;
            end
            INIT_SP: begin
                init_sp = 1'b1;
                state_d = LATCH_ADDRESS;
            end
            LATCH_ADDRESS: begin
                mem_addr_d = pc_q;
                // A new instruction must not inherit operands from the last one.
                op_clr     = (byte_idx_q == '0);
                state_d    = READ_BYTE;
            end
            READ_BYTE: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = LATCH_BYTE;
                end
            end
            LATCH_BYTE: begin
                if (byte_idx_q == '0) begin
                    opcode_d = mem_rdata;
                end else begin
                    op_wr = 1'b1;
                end
                pc_d       = pc_q + ADDR_WIDTH'(1);
                byte_idx_d = byte_idx_q + LEN_W'(1);
                state_d    = CHK_MORE_BYTES;
            end
            CHK_MORE_BYTES: begin
                // Length is decoded from the opcode, so it is valid from byte 0 on.
                if ((instr_len == '0) || (instr_len > MAX_LEN)) begin
                    len_error_d = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = HALTED;
                end else if (byte_idx_q < instr_len) begin
                    state_d = LATCH_ADDRESS;
                end else begin
                    byte_idx_d = '0;
                    exec_start = 1'b1;
                    state_d    = EXECUTE;
                end
            end
            EXECUTE: begin
                if (exec_done) begin
                    if (pc_load) begin
                        pc_d = pc_load_value;
                    end
                    if (halt_req) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        state_d = LATCH_ADDRESS;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    operand_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_LANES  (MAX_BYTES - 1),
        .IDX_W      (LEN_W)
    ) u_operands (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (op_clr),
        .wr_en_i   (op_wr),
        .wr_idx_i  (byte_idx_q),
        .wr_data_i (mem_rdata),
        .lanes_o   (operands)
    );

    assign mem_addr   = mem_addr_q;
    assign pc         = pc_q;
    assign opcode     = opcode_q;
    assign fetch_busy = fetch_busy_q;
    assign halted     = halted_q;
    assign len_error  = len_error_q;

endmodule
